// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding read at a time, returned word held until decode accepts it.
// Zero-wait memory gives one instruction per 3 cycles; memory stall waits in REQ, decode stall waits in HOLD.
module fetch_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              flush,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [ADDR_W-1:0] req_addr,
   input  logic              rsp_valid,
   input  logic [DATA_W-1:0] rsp_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              pc_advance,
   output logic [CNT_W-1:0]  fetch_count
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] HOLD = 2'd3;

   logic [1:0]        state;
   logic [ADDR_W-1:0] pc_q;
   logic              drop_q;

   assign req_valid  = (state == REQ);
   assign req_addr   = req_valid ? pc_in : '0;
   assign pc_advance = (state == HOLD) && inst_ready && !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         pc_q        <= '0;
         drop_q      <= 1'b0;
         inst_valid  <= 1'b0;
         inst_data   <= '0;
         inst_pc     <= '0;
         fetch_count <= '0;
      end else begin
         case (state)
            IDLE: state <= REQ;
            REQ: begin
               // A flush here needs no action: req_addr already follows the redirected pc_in.
               if (req_ready) begin
                  pc_q  <= pc_in;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (rsp_valid) begin
                  if (drop_q || flush) begin
                     drop_q <= 1'b0;
                     state  <= REQ;
                  end else begin
                     inst_data  <= rsp_data;
                     inst_pc    <= pc_q;
                     inst_valid <= 1'b1;
                     state      <= HOLD;
                  end
               end else if (flush) begin
                  // Response still owed by memory; remember to throw it away.
                  drop_q <= 1'b1;
               end
            end
            HOLD: begin
               if (flush || inst_ready) begin
                  inst_valid <= 1'b0;
                  state      <= REQ;
               end
               if (pc_advance) fetch_count <= fetch_count + CNT_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (CNT_W=4 so the counter wrap is reachable); memory and PC modelled below.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic [31:0] pc_in;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        pc_advance;
   logic [3:0]  fetch_count;

   logic        auto_pc;
   logic [31:0] pc_auto;
   logic [31:0] pc_man;
   int          mem_lat;
   logic [31:0] mem_base;
   int          pend_cnt;
   logic [31:0] pend_addr;
   logic        adv_s;
   logic        hs_s;
   logic [31:0] addr_s;

   int checks;
   int errors;

   fetch_unit #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
      .inst_pc(inst_pc), .pc_advance(pc_advance), .fetch_count(fetch_count)
   );

   assign pc_in = auto_pc ? pc_auto : pc_man;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // PC steps on pc_advance; memory answers an accepted request mem_lat cycles later with mem_base+addr.
   initial begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
      pend_cnt  = 0;
      pend_addr = '0;
      pc_auto   = '0;
      forever begin
         @(negedge clk);
         adv_s  = pc_advance;
         hs_s   = req_valid && req_ready;
         addr_s = req_addr;
         @(posedge clk);
         #1;
         if (!auto_pc) pc_auto = pc_man;
         else if (adv_s) pc_auto = pc_auto + 32'd1;
         rsp_valid = 1'b0;
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               rsp_valid = 1'b1;
               rsp_data  = mem_base + pend_addr;
            end
         end
         if (hs_s) begin
            if (mem_lat <= 1) begin
               rsp_valid = 1'b1;
               rsp_data  = mem_base + addr_s;
            end else begin
               pend_cnt  = mem_lat - 1;
               pend_addr = addr_s;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pe();
      @(posedge clk);
      #2;
   endtask

   task automatic ne();
      @(negedge clk);
   endtask

   task automatic wait_adv(output logic ok);
      ok = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (pc_advance) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      logic ok;
      checks     = 0;
      errors     = 0;
      rst        = 1'b0;
      flush      = 1'b0;
      req_ready  = 1'b0;
      inst_ready = 1'b0;
      auto_pc    = 1'b0;
      pc_man     = '0;
      mem_lat    = 1;
      mem_base   = 32'hA0;

      #12;
      chk("rst_req_valid", 32'(req_valid), 0);
      chk("rst_req_addr", req_addr, 0);
      chk("rst_inst_valid", 32'(inst_valid), 0);
      chk("rst_inst_data", inst_data, 0);
      chk("rst_pc_advance", 32'(pc_advance), 0);
      chk("rst_fetch_count", 32'(fetch_count), 0);
      rst        = 1'b1;
      req_ready  = 1'b1;
      inst_ready = 1'b1;
      auto_pc    = 1'b1;

      // Steady stream: REQ, WAIT, HOLD per instruction.
      for (int i = 0; i < 3; i++) begin
         ne();
         chk("s_req_valid", 32'(req_valid), 1);
         chk("s_req_addr", req_addr, 32'(i));
         ne();
         chk("s_wait_req_valid", 32'(req_valid), 0);
         chk("s_wait_adv", 32'(pc_advance), 0);
         ne();
         chk("s_inst_valid", 32'(inst_valid), 1);
         chk("s_inst_data", inst_data, 32'hA0 + 32'(i));
         chk("s_inst_pc", inst_pc, 32'(i));
         chk("s_adv", 32'(pc_advance), 1);
      end
      ne();
      chk("s_count3", 32'(fetch_count), 3);
      chk("s_req_addr3", req_addr, 3);

      // Decode backpressure in HOLD.
      mem_base   = 32'h1231;
      inst_ready = 1'b0;
      ne();
      for (int k = 0; k < 5; k++) begin
         ne();
         chk("bp_inst_valid", 32'(inst_valid), 1);
         chk("bp_inst_data", inst_data, 32'h1234);
         chk("bp_inst_pc", inst_pc, 3);
         chk("bp_adv", 32'(pc_advance), 0);
         chk("bp_req_valid", 32'(req_valid), 0);
      end
      pe();
      inst_ready = 1'b1;
      ne();
      chk("bp_adv_pulse", 32'(pc_advance), 1);
      mem_lat  = 3;
      mem_base = 32'hA0;
      pc_man   = 32'd4;
      auto_pc  = 1'b0;
      ne();
      chk("bp_adv_single", 32'(pc_advance), 0);
      chk("bp_inst_valid_clr", 32'(inst_valid), 0);
      chk("bp_count4", 32'(fetch_count), 4);
      chk("bp_req_addr4", req_addr, 4);

      // Flush while the read for address 4 is outstanding.
      pe();
      flush  = 1'b1;
      pc_man = 32'h20;
      ne();
      chk("fw_req_valid", 32'(req_valid), 0);
      pe();
      flush = 1'b0;
      ne();
      chk("fw_inst_valid_a", 32'(inst_valid), 0);
      ne();
      chk("fw_inst_valid_b", 32'(inst_valid), 0);
      chk("fw_req_valid_b", 32'(req_valid), 0);
      ne();
      chk("fw_req_valid_c", 32'(req_valid), 1);
      chk("fw_req_addr", req_addr, 32'h20);
      chk("fw_inst_valid_c", 32'(inst_valid), 0);
      chk("fw_count", 32'(fetch_count), 4);
      mem_lat = 1;

      // Flush together with inst_ready in HOLD.
      pe();
      pe();
      flush = 1'b1;
      ne();
      chk("fh_inst_valid", 32'(inst_valid), 1);
      chk("fh_inst_data", inst_data, 32'hC0);
      chk("fh_inst_pc", inst_pc, 32'h20);
      chk("fh_adv", 32'(pc_advance), 0);
      pe();
      flush     = 1'b0;
      req_ready = 1'b0;
      pc_man    = 32'h30;

      // Memory not ready for four cycles.
      for (int k = 0; k < 4; k++) begin
         ne();
         chk("rr_req_valid", 32'(req_valid), 1);
         chk("rr_req_addr", req_addr, 32'h30);
         chk("rr_inst_valid", 32'(inst_valid), 0);
         chk("rr_count", 32'(fetch_count), 4);
      end
      pe();
      req_ready = 1'b1;
      mem_lat   = 3;
      ne();
      chk("rr_req_valid_5", 32'(req_valid), 1);
      ne();
      chk("rr_wait", 32'(req_valid), 0);

      // Asynchronous reset in WAIT, response arrives after release.
      #1;
      rst       = 1'b0;
      req_ready = 1'b0;
      #1;
      chk("ar_req_valid", 32'(req_valid), 0);
      chk("ar_req_addr", req_addr, 0);
      chk("ar_inst_valid", 32'(inst_valid), 0);
      chk("ar_inst_data", inst_data, 0);
      chk("ar_inst_pc", inst_pc, 0);
      chk("ar_adv", 32'(pc_advance), 0);
      chk("ar_count", 32'(fetch_count), 0);
      #1;
      rst    = 1'b1;
      pc_man = '0;
      for (int k = 0; k < 3; k++) begin
         ne();
         chk("ar_late_inst_valid", 32'(inst_valid), 0);
         chk("ar_late_req_valid", 32'(req_valid), 1);
      end

      // Counter wrap: 16 accepts on a 4-bit counter.
      pe();
      mem_lat    = 1;
      req_ready  = 1'b1;
      inst_ready = 1'b1;
      auto_pc    = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wait_adv(ok);
         chk("wr_adv_seen", 32'(ok), 1);
         chk("wr_count", 32'(fetch_count), 32'(i));
      end
      ne();
      chk("wr_wrapped", 32'(fetch_count), 0);
      chk("wr_adv_low", 32'(pc_advance), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage. It sits between the program counter and the instruction memory port, and is the consumer side of the PC's address output. It reads the current word address, issues one read request at a time over a valid/ready memory handshake, and holds the returned instruction for decode until decode accepts it. It then pulses pc_advance so the PC steps; a flush from branch/jump resolution discards any stale fetch.

Parameters:
ADDR_W, 32, width of PC word address and req_addr
DATA_W, 32, instruction width
CNT_W, 16, width of delivered-instruction counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
pc_in  in  ADDR_W  current PC word address
flush  in  1  redirect (branch taken or jump); discard in-flight/held fetch
req_valid  out  1  memory read request valid
req_ready  in  1  memory accepts request
req_addr  out  ADDR_W  request address (= pc_in while in REQ)
rsp_valid  in  1  read data valid (one per accepted request, latency >= 1 cycle)
rsp_data  in  DATA_W  read data
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst_data  out  DATA_W  held instruction
inst_pc  out  ADDR_W  address the held instruction was fetched from
pc_advance  out  1  one-cycle pulse: PC may step
fetch_count  out  CNT_W  count of instructions accepted by decode, wraps

Behaviour:
- States: IDLE, REQ, WAIT, HOLD. Reset (rst=0, async) forces IDLE, drop_q=0, inst_valid=0, inst_data=0, inst_pc=0, pc_advance=0, fetch_count=0; req_valid=0, req_addr=0.
- IDLE -> REQ unconditionally on the next clk after reset release.
- REQ: req_valid=1, req_addr=pc_in (combinational). On req_valid&&req_ready: latch pc_in into pc_q, go WAIT. flush in REQ: no effect (nothing in flight), stay REQ, keep presenting the redirected pc_in.
- WAIT: req_valid=0; at most one outstanding request. On rsp_valid:
  - drop_q=1 or flush=1: discard, clear drop_q, go REQ.
  - otherwise: inst_data<=rsp_data, inst_pc<=pc_q, inst_valid<=1, go HOLD.
  - flush without rsp_valid: set drop_q, stay WAIT.
- HOLD: inst_valid=1, inst_data and inst_pc stable.
  - inst_ready=1 and flush=0: pc_advance=1 for this cycle (combinational on handshake), fetch_count+1 (wraps at 2^CNT_W), clear inst_valid, go REQ.
  - flush=1, regardless of inst_ready: clear inst_valid, no pc_advance, no count, go REQ.
- Latency: with zero-wait req_ready and 1-cycle rsp, an instruction is delivered every 3 cycles when inst_ready is held at 1 (REQ, WAIT, HOLD).
- pc_advance never asserts outside HOLD and never in a cycle with flush=1.
- rsp_valid outside WAIT is ignored.
- Reset mid-operation: an outstanding response arriving after reset release is ignored, because the block is in IDLE/REQ.

Test Plan:
- Reset then steady stream: pc_in=0,1,2 (advancing on pc_advance), memory req_ready=1, 1-cycle rsp returns 0xA0+addr, inst_ready=1 -> inst_data 0xA0,0xA1,0xA2 with inst_pc 0,1,2, pc_advance every 3rd cycle, fetch_count=3.
- Backpressure: inst_ready=0 for 5 cycles in HOLD with inst_data=0x1234 -> inst_valid held, data stable, no pc_advance, no new req_valid; inst_ready=1 -> single pc_advance pulse.
- Flush in WAIT: request addr 4 accepted, flush pulse 1 cycle, pc_in=0x20, rsp arrives 3 cycles later -> response dropped, inst_valid stays 0, next req_addr=0x20, fetch_count unchanged.
- Flush and inst_ready same cycle in HOLD -> inst_valid drops, pc_advance=0, fetch_count unchanged, next state REQ.
- req_ready held low 4 cycles -> req_valid=1, req_addr=pc_in stable; accept on 5th cycle -> WAIT.
- Async reset asserted in WAIT mid-cycle -> all outputs 0 immediately; late rsp_valid=1 after release ignored; fetch_count counter wrap checked with CNT_W=4: 16 accepts -> 0.
